fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch queue. It drives the instruction memory address and captures the combinational read data into a DEPTH-entry FIFO of {pc, instr} pairs. Decode pulls entries through a valid/ready handshake. The block supports jump redirection with queue flush, a sticky halt that injects NOPs, and end-of-program saturation. It sits between the instruction ROM and the decode/control stage and replaces the fixed 5-bit, unbuffered PC logic.

---
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect/halt controls and the
// decode-side valid/ready stream. master = fetch_queue, slave = its environment.
interface fetch_queue_if #(
    parameter int PC_W  = 5,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] imem_addr;
    logic [XLEN-1:0] imem_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [PC_W-1:0] out_pc;
    logic [PC_W-1:0] pc;
    logic [CW-1:0]   count;
    logic            halted;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, pc, count, halted,
        input  imem_data, redirect, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, pc, count, halted,
        output imem_data, redirect, redirect_pc, halt, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: walks the PC, captures {pc, instr} pairs into a
// circular prefetch queue, and supports jump redirect, sticky halt and end-of-ROM stop.
module fetch_queue #(
    parameter int              PC_W  = 5,
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 4,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
    input logic             clk,
    input logic             rst_n,
    fetch_queue_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [PC_W-1:0] pc_reg;
    logic            done_reg;
    logic            halted_reg;

    logic empty;
    logic pop;
    logic push;
    logic flush_halt;

    assign empty      = (count_reg == '0);
    assign flush_halt = bus.halt | halted_reg;
    assign pop        = ~halted_reg & ~empty & bus.out_ready;
    // A push is suppressed whenever halt or redirect takes over the cycle.
    assign push       = ~flush_halt & ~done_reg & ~bus.redirect &
                        ((count_reg < CW'(DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            pc_reg     <= '0;
            done_reg   <= 1'b0;
            halted_reg <= 1'b0;
        end else if (flush_halt) begin
            halted_reg <= 1'b1;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (bus.redirect) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            pc_reg     <= bus.redirect_pc;
            done_reg   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                // The last address is fetched once; pc then parks there.
                if (pc_reg == {PC_W{1'b1}}) begin
                    done_reg <= 1'b1;
                end else begin
                    pc_reg <= pc_reg + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Storage has no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= '{pc: pc_reg, instr: bus.imem_data};
        end
    end

    assign bus.imem_addr = pc_reg;
    assign bus.pc        = pc_reg;
    assign bus.count     = count_reg;
    assign bus.halted    = halted_reg;
    assign bus.out_valid = halted_reg | ~empty;
    assign bus.out_instr = (halted_reg | empty) ? NOP : mem[rd_ptr_reg].instr;
    assign bus.out_pc    = (halted_reg | empty) ? '0 : mem[rd_ptr_reg].pc;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM[i] = i + 100, checks streaming,
// back-pressure, redirect, end-of-program and halt behaviour.
module tb_fetch_queue;
    localparam int PC_W  = 5;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [XLEN-1:0] NOP = 32'h00000013;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_if #(.PC_W(PC_W), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.PC_W(PC_W), .XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_data = XLEN'(bus.imem_addr) + 32'd100;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.pc !== 5'd0 || bus.count !== 3'd0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%0d count=%0d halted=%0b expected 0/0/0",
                     bus.pc, bus.count, bus.halted);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP || bus.out_pc !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs valid=%0b instr=%h pc=%0d expected 0/%h/0",
                     bus.out_valid, bus.out_instr, bus.out_pc, NOP);
        end
        $display("reset: pc=%0d count=%0d valid=%0b", bus.pc, bus.count, bus.out_valid);
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'(k) ||
                bus.out_instr !== 32'(k + 100) || bus.count !== 3'd1 ||
                bus.pc !== 5'(k + 1)) begin
                errors++;
                $display("FAIL stream[%0d] valid=%0b pc=%0d instr=%0d count=%0d fpc=%0d expected 1/%0d/%0d/1/%0d",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, bus.count, bus.pc,
                         k, k + 100, k + 1);
            end
            $display("stream: out_pc=%0d instr=%0d count=%0d", bus.out_pc, bus.out_instr, bus.count);
        end
    endtask

    task automatic test_backpressure();
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (bus.count !== 3'd4 || bus.pc !== 5'd4 || bus.out_pc !== 5'd0) begin
            errors++;
            $display("FAIL bp_full count=%0d pc=%0d head=%0d expected 4/4/0",
                     bus.count, bus.pc, bus.out_pc);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'(k) ||
                bus.out_instr !== 32'(k + 100) || bus.count !== 3'd4) begin
                errors++;
                $display("FAIL bp_drain[%0d] valid=%0b pc=%0d instr=%0d count=%0d expected 1/%0d/%0d/4",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, bus.count, k, k + 100);
            end
            $display("backpressure: out_pc=%0d count=%0d", bus.out_pc, bus.count);
            bus.out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_redirect();
        bus.out_ready = 1'b0;
        tick();
        checks++;
        if (bus.count !== 3'd4 || bus.pc !== 5'd12) begin
            errors++;
            $display("FAIL redir_prefull count=%0d pc=%0d expected 4/12", bus.count, bus.pc);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd17;
        tick();
        bus.redirect = 1'b0;
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.pc !== 5'd17) begin
            errors++;
            $display("FAIL redir_flush count=%0d valid=%0b pc=%0d expected 0/0/17",
                     bus.count, bus.out_valid, bus.pc);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'(17 + k) ||
                bus.out_instr !== 32'(117 + k) || bus.count !== 3'd1) begin
                errors++;
                $display("FAIL redir_target[%0d] valid=%0b pc=%0d instr=%0d count=%0d expected 1/%0d/%0d/1",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, bus.count, 17 + k, 117 + k);
            end
            $display("redirect: out_pc=%0d instr=%0d", bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_end_of_program();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd28;
        tick();
        bus.redirect = 1'b0;
        for (int k = 28; k < 32; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'(k) || bus.out_instr !== 32'(k + 100)) begin
                errors++;
                $display("FAIL end_entry[%0d] valid=%0b pc=%0d instr=%0d expected 1/%0d/%0d",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, k, k + 100);
            end
            $display("end: out_pc=%0d fetch_pc=%0d", bus.out_pc, bus.pc);
        end
        checks++;
        if (bus.pc !== 5'd31) begin
            errors++;
            $display("FAIL end_pc_hold pc=%0d expected 31", bus.pc);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.pc !== 5'd31) begin
                errors++;
                $display("FAIL end_drained[%0d] valid=%0b count=%0d pc=%0d expected 0/0/31",
                         k, bus.out_valid, bus.count, bus.pc);
            end
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd3;
        tick();
        bus.redirect = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd3 || bus.out_instr !== 32'd103) begin
            errors++;
            $display("FAIL end_resume valid=%0b pc=%0d instr=%0d expected 1/3/103",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        $display("end: resumed at out_pc=%0d", bus.out_pc);
    endtask

    task automatic test_halt_redirect();
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL halt_prefill count=%0d expected 3", bus.count);
        end
        bus.halt        = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd9;
        tick();
        bus.halt     = 1'b0;
        bus.redirect = 1'b0;
        checks++;
        if (bus.halted !== 1'b1 || bus.count !== 3'd0 || bus.out_valid !== 1'b1 ||
            bus.out_instr !== NOP || bus.out_pc !== 5'd0 || bus.pc !== 5'd3) begin
            errors++;
            $display("FAIL halt_enter halted=%0b count=%0d valid=%0b instr=%h opc=%0d pc=%0d expected 1/0/1/%h/0/3",
                     bus.halted, bus.count, bus.out_valid, bus.out_instr, bus.out_pc, bus.pc, NOP);
        end
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd20;
        tick();
        bus.redirect = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_instr !== NOP ||
            bus.pc !== 5'd3 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL halt_sticky halted=%0b valid=%0b instr=%h pc=%0d count=%0d expected 1/1/%h/3/0",
                     bus.halted, bus.out_valid, bus.out_instr, bus.pc, bus.count, NOP);
        end
        $display("halt: halted=%0b instr=%h", bus.halted, bus.out_instr);
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0 || bus.pc !== 5'd0) begin
            errors++;
            $display("FAIL halt_reset halted=%0b valid=%0b pc=%0d expected 0/0/0",
                     bus.halted, bus.out_valid, bus.pc);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd0 || bus.out_instr !== 32'd100) begin
            errors++;
            $display("FAIL halt_restart valid=%0b pc=%0d instr=%0d expected 1/0/100",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        $display("halt: after reset out_pc=%0d instr=%0d", bus.out_pc, bus.out_instr);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_end_of_program();
        test_halt_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
